mash_combiner: RTL and testbench

Parametrised error-cancellation network for the MASH delta-sigma modulator: it combines the carry outputs of up to `MAX_ORDER` cascaded accumulator stages into one signed fractional output. Stage k is weighted by the shaping polynomial (1 − z⁻¹)^(k−1). The block sits between the MASH accumulator chain and the divider-control adder. It supersedes the fixed 3-stage noise shaper and adds a sample strobe, runtime order select, an output valid flag and optional saturation.

---
 rtl/mash_combiner_if.sv | 35 +++
 rtl/mash_combiner.sv | 186 ++++++++++++++++++
 tb/tb_mash_combiner.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mash_combiner_if.sv
// mash_combiner_if
//   Sample-side bundle of the MASH error-cancellation combiner.
//   master : accumulator chain / bench side, drives the strobe, carries and
//            requested order, receives the combined output and flags.
//   slave  : the combiner itself.
//   Signals:
//     en        sample strobe, one carry vector consumed per en=1 cycle
//     carry_in  bit k-1 is the carry of stage k
//     order_sel requested modulator order (clamped inside to 1..MAX_ORDER)
//     out_f     signed combined output, OUT_W bits
//     out_valid one-cycle pulse marking a new out_f
//     order_chg pulses with out_valid on the first sample after an order change
//     sat       pulses with out_valid when out_f was clamped
interface mash_combiner_if #(
  parameter int MAX_ORDER = 3,
  parameter int OUT_W     = 5
);
  logic                    en;
  logic [MAX_ORDER-1:0]    carry_in;
  logic [2:0]              order_sel;
  logic signed [OUT_W-1:0] out_f;
  logic                    out_valid;
  logic                    order_chg;
  logic                    sat;

  modport master (
    output en, carry_in, order_sel,
    input  out_f, out_valid, order_chg, sat
  );

  modport slave (
    input  en, carry_in, order_sel,
    output out_f, out_valid, order_chg, sat
  );
endinterface

// File: rtl/mash_combiner.sv
// mash_combiner
//   Error-cancellation network of a MASH delta-sigma modulator. Stage k's
//   carry is filtered by (1 - z^-1)^(k-1) and all active stages are summed
//   into one signed output. The order K is selectable at runtime; stages above
//   K are masked. Switching K clears every history so the new order starts
//   from a clean state.
//   Ports:
//     clk    clock
//     rst_n  asynchronous active-low reset
//     bus    mash_combiner_if.slave (en, carry_in, order_sel in;
//            out_f, out_valid, order_chg, sat out)
//   Parameters: MAX_ORDER (1..4), OUT_W (output width).
//   Build option: define MASH_COMB_SAT_EN to clamp the output to the OUT_W
//   signed range and report clamps on sat; otherwise the output wraps and
//   sat is tied low.
module mash_combiner #(
  parameter int MAX_ORDER = 3,
  parameter int OUT_W     = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  mash_combiner_if.slave  bus
);

  // Internal sum width is fixed at 6 bits (range -7..8 at order 4); widen
  // only when the output itself is wider.
  localparam int EXT_W = (OUT_W > 6) ? OUT_W : 6;

  // Binomial weights with alternating sign: taps of (1 - z^-1)^(k-1).
  function automatic logic signed [5:0] coef(input int k, input int j);
    logic signed [5:0] c;
    c = 6'sd0;
    case (k)
      1: c = 6'sd1;
      2: c = (j == 0) ? 6'sd1 : -6'sd1;
      3: begin
        case (j)
          0:       c = 6'sd1;
          1:       c = -6'sd2;
          default: c = 6'sd1;
        endcase
      end
      default: begin
        case (j)
          0:       c = 6'sd1;
          1:       c = -6'sd3;
          2:       c = 6'sd3;
          default: c = -6'sd1;
        endcase
      end
    endcase
    return c;
  endfunction

  logic [2:0]           k_eff;
  logic [2:0]           k_q;
  logic                 chg;
  logic [MAX_ORDER-1:0] c_m;
  logic signed [5:0]    y;

  always_comb begin
    k_eff = bus.order_sel;
    if (bus.order_sel == 3'd0) begin
      k_eff = 3'd1;
    end else if (int'(bus.order_sel) > MAX_ORDER) begin
      k_eff = 3'(MAX_ORDER);
    end
  end

  assign chg = bus.en && (k_eff != k_q);

  always_comb begin
    c_m = '0;
    for (int k = 0; k < MAX_ORDER; k++) begin
      c_m[k] = bus.carry_in[k] && (k < int'(k_eff));
    end
  end

  // One block per stage: its own history and weighted term, plus a running
  // sum chained from the previous stage.
  for (genvar k = 1; k <= MAX_ORDER; k++) begin : g_st
    logic signed [5:0] s;
    logic signed [5:0] acc;

    if (k == 1) begin : g_first
      assign s = c_m[0] ? 6'sd1 : 6'sd0;
    end else begin : g_hist
      // hist[j-1] holds c_k[n-j]; an order change makes the delayed taps
      // read as zero for this sample and restarts the shift from zero.
      logic [k-2:0] hist;
      logic [k-2:0] base;

      assign base = chg ? '0 : hist;

      if (k == 2) begin : g_sh1
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            hist <= '0;
          end else if (bus.en) begin
            hist <= c_m[1];
          end
        end
      end else begin : g_shn
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            hist <= '0;
          end else if (bus.en) begin
            hist <= {base[k-3:0], c_m[k-1]};
          end
        end
      end

      always_comb begin
        s = c_m[k-1] ? coef(k, 0) : 6'sd0;
        for (int j = 1; j < k; j++) begin
          if (base[j-1]) begin
            s = s + coef(k, j);
          end
        end
      end
    end

    if (k == 1) begin : g_acc0
      assign acc = s;
    end else begin : g_accn
      assign acc = g_st[k-1].acc + s;
    end
  end

  assign y = g_st[MAX_ORDER].acc;

  logic signed [EXT_W-1:0] y_ext;
  logic signed [OUT_W-1:0] out_next;
  logic                    sat_next;

  assign y_ext = EXT_W'(y);

`ifdef MASH_COMB_SAT_EN
  localparam logic signed [EXT_W-1:0] OUT_MAX = EXT_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] OUT_MIN = EXT_W'(-(1 << (OUT_W - 1)));

  always_comb begin
    sat_next = 1'b0;
    out_next = OUT_W'(y_ext);
    if (y_ext > OUT_MAX) begin
      out_next = OUT_W'(OUT_MAX);
      sat_next = 1'b1;
    end else if (y_ext < OUT_MIN) begin
      out_next = OUT_W'(OUT_MIN);
      sat_next = 1'b1;
    end
  end
`else
  assign out_next = OUT_W'(y_ext);
  assign sat_next = 1'b0;
`endif

  logic signed [OUT_W-1:0] out_q;
  logic                    valid_q;
  logic                    chg_q;
  logic                    sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      chg_q   <= 1'b0;
      sat_q   <= 1'b0;
      k_q     <= 3'(MAX_ORDER);
    end else begin
      valid_q <= bus.en;
      chg_q   <= chg;
      sat_q   <= bus.en && sat_next;
      if (bus.en) begin
        out_q <= out_next;
        k_q   <= k_eff;
      end
    end
  end

  assign bus.out_f     = out_q;
  assign bus.out_valid = valid_q;
  assign bus.order_chg = chg_q;
  assign bus.sat       = sat_q;

endmodule

// File: tb/tb_mash_combiner.sv
// tb_mash_combiner
//   Two combiners: A (MAX_ORDER=3, OUT_W=5) and B (MAX_ORDER=4, OUT_W=3).
//   Each strobe pushes the reference-model result to a per-DUT scoreboard
//   queue; a negedge monitor pops and compares on out_valid and checks that
//   out_f/flags hold between pulses. Scenario tasks add literal checks.
//   Honours MASH_COMB_SAT_EN for the expected narrowing.
module tb_mash_combiner;

  typedef struct {
    int f;
    bit chg;
    bit sat;
    int cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   passed;

  exp_t   q3[$];
  exp_t   q4[$];
  int     obs3[$];
  int     obs4[$];
  integer held3;
  integer held4;

  int mh[2][1:4][0:3];
  int mk[2];
  int mmax[2];
  int mw[2];

  mash_combiner_if #(.MAX_ORDER(3), .OUT_W(5)) bus3 ();
  mash_combiner_if #(.MAX_ORDER(4), .OUT_W(3)) bus4 ();

  mash_combiner #(.MAX_ORDER(3), .OUT_W(5)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );
  mash_combiner #(.MAX_ORDER(4), .OUT_W(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int binom(input int n, input int r);
    int v;
    v = 1;
    for (int i = 0; i < r; i++) v = v * (n - i) / (i + 1);
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mk[d] = mmax[d];
      for (int s = 1; s <= 4; s++)
        for (int j = 0; j < 4; j++) mh[d][s][j] = 0;
    end
  endtask

  task automatic model_step(input int d, input logic [3:0] c, input logic [2:0] s,
                            output exp_t e);
    int k;
    int y;
    int lim;
    k = int'(s);
    if (k < 1) k = 1;
    if (k > mmax[d]) k = mmax[d];
    e.chg = (k != mk[d]);
    if (e.chg)
      for (int st = 1; st <= 4; st++)
        for (int j = 0; j < 4; j++) mh[d][st][j] = 0;
    y = 0;
    for (int st = 1; st <= mmax[d]; st++) begin
      mh[d][st][0] = (st <= k) ? int'(c[st-1]) : 0;
      for (int j = 0; j < st; j++)
        y += ((j % 2) ? -1 : 1) * binom(st - 1, j) * mh[d][st][j];
      for (int j = 3; j > 0; j--) mh[d][st][j] = mh[d][st][j-1];
    end
    mk[d] = k;
    lim = 1 << (mw[d] - 1);
`ifdef MASH_COMB_SAT_EN
    e.sat = 1'b0;
    e.f = y;
    if (y > lim - 1) begin e.f = lim - 1; e.sat = 1'b1; end
    if (y < -lim)    begin e.f = -lim;    e.sat = 1'b1; end
`else
    e.sat = 1'b0;
    e.f = y & ((1 << mw[d]) - 1);
    if (e.f >= lim) e.f -= (1 << mw[d]);
`endif
  endtask

  // Called right after a negedge; returns #1 after the next negedge.
  task automatic drive(input int d, input bit e, input logic [3:0] c, input logic [2:0] s);
    exp_t x;
    if (d == 0) begin
      bus3.en = e; bus3.carry_in = c[2:0]; bus3.order_sel = s; bus4.en = 1'b0;
    end else begin
      bus4.en = e; bus4.carry_in = c; bus4.order_sel = s; bus3.en = 1'b0;
    end
    if (e) begin
      model_step(d, c, s, x);
      x.cyc = cyc + 1;
      if (d == 0) q3.push_back(x);
      else q4.push_back(x);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic clear_state();
    q3.delete(); q4.delete();
    held3 = 0; held4 = 0;
    model_reset();
  endtask

  task automatic reset_pulse();
    bus3.en = 1'b0; bus4.en = 1'b0;
    rst_n = 1'b0;
    clear_state();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    integer g;
    exp_t x;
    if (rst_n) begin
      g = bus3.out_f;
      checks++;
      if (bus3.out_valid === 1'b1) begin
        if (q3.size() == 0) begin
          $display("FAIL sb3_extra: out_valid with nothing pending, out_f=%0d", g);
        end else begin
          x = q3.pop_front();
          if (g !== x.f || bus3.order_chg !== x.chg || bus3.sat !== x.sat || cyc !== x.cyc)
            $display("FAIL sb3: got f=%0d chg=%b sat=%b cyc=%0d, expected f=%0d chg=%b sat=%b cyc=%0d",
                     g, bus3.order_chg, bus3.sat, cyc, x.f, x.chg, x.sat, x.cyc);
          else passed++;
        end
        obs3.push_back(g);
        held3 = g;
      end else if (g !== held3 || bus3.order_chg !== 1'b0 || bus3.sat !== 1'b0 || bus3.out_valid !== 1'b0) begin
        $display("FAIL hold3: got f=%0d chg=%b sat=%b valid=%b, expected f=%0d with flags low",
                 g, bus3.order_chg, bus3.sat, bus3.out_valid, held3);
      end else passed++;

      g = bus4.out_f;
      checks++;
      if (bus4.out_valid === 1'b1) begin
        if (q4.size() == 0) begin
          $display("FAIL sb4_extra: out_valid with nothing pending, out_f=%0d", g);
        end else begin
          x = q4.pop_front();
          if (g !== x.f || bus4.order_chg !== x.chg || bus4.sat !== x.sat || cyc !== x.cyc)
            $display("FAIL sb4: got f=%0d chg=%b sat=%b cyc=%0d, expected f=%0d chg=%b sat=%b cyc=%0d",
                     g, bus4.order_chg, bus4.sat, cyc, x.f, x.chg, x.sat, x.cyc);
          else passed++;
        end
        obs4.push_back(g);
        held4 = g;
      end else if (g !== held4 || bus4.order_chg !== 1'b0 || bus4.sat !== 1'b0 || bus4.out_valid !== 1'b0) begin
        $display("FAIL hold4: got f=%0d chg=%b sat=%b valid=%b, expected f=%0d with flags low",
                 g, bus4.order_chg, bus4.sat, bus4.out_valid, held4);
      end else passed++;
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 4; i++) drive(0, 1'b1, 4'($urandom_range(0, 7)), 3'd3);
    bus3.en = 1'b1; bus3.carry_in = 3'b111; bus3.order_sel = 3'd3;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus3.out_valid, bus3.order_chg, bus3.sat, bus3.out_f} !== 8'd0 ||
        {bus4.out_valid, bus4.order_chg, bus4.sat, bus4.out_f} !== 6'd0)
      $display("FAIL reset_async: A={v%b c%b s%b f%0d} B={v%b c%b s%b f%0d}, expected all 0",
               bus3.out_valid, bus3.order_chg, bus3.sat, bus3.out_f,
               bus4.out_valid, bus4.order_chg, bus4.sat, bus4.out_f);
    else passed++;
    clear_state();
    @(negedge clk);
    #1;
    checks++;
    if (bus3.out_valid !== 1'b0 || bus3.out_f !== 5'sd0)
      $display("FAIL reset_hold: valid=%b f=%0d with en=1 in reset, expected 0/0",
               bus3.out_valid, bus3.out_f);
    else passed++;
    bus3.en = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus3.out_valid !== 1'b0 || bus3.out_f !== 5'sd0 || bus4.out_valid !== 1'b0 || bus4.out_f !== 3'sd0)
        $display("FAIL idle_after_reset: A valid=%b f=%0d, B valid=%b f=%0d, expected 0",
                 bus3.out_valid, bus3.out_f, bus4.out_valid, bus4.out_f);
      else passed++;
    end
  endtask

  task automatic test_const_stage1();
    integer g;
    obs3.delete();
    drive(0, 1'b1, 4'b0001, 3'd3);
    g = bus3.out_f;
    checks++;
    if (bus3.out_valid !== 1'b1 || g !== 1)
      $display("FAIL const_latency: valid=%b f=%0d one cycle after strobe, expected 1/1",
               bus3.out_valid, g);
    else passed++;
    for (int i = 0; i < 7; i++) drive(0, 1'b1, 4'b0001, 3'd3);
    drive(0, 1'b0, 4'b0001, 3'd3);
    for (int i = 0; i < obs3.size(); i++) begin
      checks++;
      if (obs3[i] !== 1) $display("FAIL const_stage1[%0d]: got %0d, expected 1", i, obs3[i]);
      else passed++;
    end
  endtask

  task automatic test_impulse3();
    int exp_seq[4];
    exp_seq = '{1, -2, 1, 0};
    obs3.delete();
    drive(0, 1'b1, 4'b0100, 3'd3);
    for (int i = 0; i < 3; i++) drive(0, 1'b1, 4'b0000, 3'd3);
    drive(0, 1'b0, 4'b0000, 3'd3);
    checks++;
    if (obs3.size() != 4) $display("FAIL impulse3_count: got %0d outputs, expected 4", obs3.size());
    else passed++;
    for (int i = 0; i < 4 && i < obs3.size(); i++) begin
      checks++;
      if (obs3[i] !== exp_seq[i]) $display("FAIL impulse3[%0d]: got %0d, expected %0d", i, obs3[i], exp_seq[i]);
      else passed++;
    end
  endtask

  task automatic test_impulse4();
    int exp_seq[5];
    exp_seq = '{1, -3, 3, -1, 0};
    obs4.delete();
    drive(1, 1'b1, 4'b1000, 3'd4);
    for (int i = 0; i < 4; i++) drive(1, 1'b1, 4'b0000, 3'd4);
    drive(1, 1'b0, 4'b0000, 3'd4);
    checks++;
    if (obs4.size() != 5) $display("FAIL impulse4_count: got %0d outputs, expected 5", obs4.size());
    else passed++;
    for (int i = 0; i < 5 && i < obs4.size(); i++) begin
      checks++;
      if (obs4[i] !== exp_seq[i]) $display("FAIL impulse4[%0d]: got %0d, expected %0d", i, obs4[i], exp_seq[i]);
      else passed++;
    end
  endtask

  task automatic test_strobe_gaps();
    int exp_seq[4];
    integer g;
    logic [3:0] c;
    exp_seq = '{1, -2, 1, 0};
    obs3.delete();
    for (int n = 0; n < 4; n++) begin
      c = (n == 0) ? 4'b0100 : 4'b0000;
      drive(0, 1'b1, c, 3'd3);
      for (int i = 0; i < 2; i++) begin
        drive(0, 1'b0, 4'b0111, 3'd1);
        g = bus3.out_f;
        checks++;
        if (bus3.out_valid !== 1'b0 || g !== exp_seq[n])
          $display("FAIL gap_hold[%0d]: valid=%b f=%0d, expected 0/%0d", n, bus3.out_valid, g, exp_seq[n]);
        else passed++;
      end
    end
    for (int i = 0; i < 4 && i < obs3.size(); i++) begin
      checks++;
      if (obs3[i] !== exp_seq[i]) $display("FAIL gaps[%0d]: got %0d, expected %0d", i, obs3[i], exp_seq[i]);
      else passed++;
    end
  endtask

  task automatic test_order_switch();
    integer g;
    for (int i = 0; i < 4; i++) drive(0, 1'b1, 4'b0111, 3'd3);
    drive(0, 1'b1, 4'b0111, 3'd1);
    g = bus3.out_f;
    checks++;
    if (g !== 1 || bus3.order_chg !== 1'b1)
      $display("FAIL order_to_1: f=%0d chg=%b, expected 1/1", g, bus3.order_chg);
    else passed++;
    drive(0, 1'b1, 4'b0111, 3'd1);
    g = bus3.out_f;
    checks++;
    if (g !== 1 || bus3.order_chg !== 1'b0)
      $display("FAIL order_1_held: f=%0d chg=%b, expected 1/0", g, bus3.order_chg);
    else passed++;
    drive(0, 1'b0, 4'b0111, 3'd2);
    drive(0, 1'b0, 4'b0111, 3'd2);
    drive(0, 1'b1, 4'b0111, 3'd7);
    g = bus3.out_f;
    checks++;
    if (g !== 3 || bus3.order_chg !== 1'b1)
      $display("FAIL order_clamp_7: f=%0d chg=%b, expected 3/1", g, bus3.order_chg);
    else passed++;
    drive(0, 1'b1, 4'b0111, 3'd7);
    g = bus3.out_f;
    checks++;
    if (g !== 0 || bus3.order_chg !== 1'b0)
      $display("FAIL order_3_refill: f=%0d chg=%b, expected 0/0", g, bus3.order_chg);
    else passed++;
    drive(0, 1'b1, 4'b0111, 3'd3);
    checks++;
    if (bus3.order_chg !== 1'b0)
      $display("FAIL order_same: chg=%b for order 7 -> 3, expected 0", bus3.order_chg);
    else passed++;
  endtask

  task automatic test_fresh_after_reset();
    integer g;
    reset_pulse();
    drive(0, 1'b1, 4'b0111, 3'd2);
    g = bus3.out_f;
    checks++;
    if (g !== 2 || bus3.order_chg !== 1'b1)
      $display("FAIL fresh_order2: f=%0d chg=%b, expected 2/1", g, bus3.order_chg);
    else passed++;
    drive(0, 1'b1, 4'b0111, 3'd3);
    g = bus3.out_f;
    checks++;
    if (g !== 3 || bus3.order_chg !== 1'b1)
      $display("FAIL fresh_order3: f=%0d chg=%b, expected 3/1", g, bus3.order_chg);
    else passed++;
  endtask

  task automatic test_saturation();
    integer g;
    int ef;
    bit es;
`ifdef MASH_COMB_SAT_EN
    ef = 3; es = 1'b1;
`else
    ef = 0; es = 1'b0;
`endif
    for (int i = 0; i < 4; i++) drive(1, 1'b1, 4'b0000, 3'd4);
    drive(1, 1'b1, 4'b0001, 3'd4);
    drive(1, 1'b1, 4'b1111, 3'd4);
    drive(1, 1'b1, 4'b0001, 3'd4);
    drive(1, 1'b1, 4'b1111, 3'd4);
    g = bus4.out_f;
    checks++;
    if (g !== ef || bus4.sat !== es)
      $display("FAIL sat_y8: f=%0d sat=%b, expected %0d/%b", g, bus4.sat, ef, es);
    else passed++;
    drive(1, 1'b0, 4'b0000, 3'd4);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++)
      drive(0, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    for (int i = 0; i < 40; i++)
      drive(1, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
    drive(1, 1'b0, 4'b0000, 3'd4);
  endtask

  task automatic check_drained(input string tag);
    checks++;
    if (q3.size() != 0 || q4.size() != 0)
      $display("FAIL drained_%s: pending A=%0d B=%0d, expected 0/0", tag, q3.size(), q4.size());
    else passed++;
  endtask

  initial begin
    checks = 0; passed = 0; cyc = 0;
    mmax[0] = 3; mw[0] = 5;
    mmax[1] = 4; mw[1] = 3;
    bus3.en = 1'b0; bus3.carry_in = '0; bus3.order_sel = 3'd3;
    bus4.en = 1'b0; bus4.carry_in = '0; bus4.order_sel = 3'd4;
    rst_n = 1'b0;
    clear_state();
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;

    test_reset();              check_drained("reset");
    test_const_stage1();       check_drained("const");
    test_impulse3();           check_drained("imp3");
    test_impulse4();           check_drained("imp4");
    test_strobe_gaps();        check_drained("gaps");
    test_order_switch();       check_drained("order");
    test_fresh_after_reset();  check_drained("fresh");
    test_saturation();         check_drained("sat");
    test_back_to_back();       check_drained("b2b");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
